issue_ctrl: RTL and testbench
=============================

Name: issue_ctrl

Overview:
Sequencing controller for the issue stage. It decides each cycle whether the instruction at issue may fire. It also produces the `branch_pending`, `resolve` and `kill` controls the issue stage consumes. It tracks outstanding unresolved branches and in-flight memory ops, sequences a fixed-length flush after a mispredict, and drains the machine after a halt. It sits between the IS stage, the ROB/RS occupancy signals and the branch-resolution path from execute.

Parameters:
MAX_BRANCHES, 4, max unresolved branches in flight; counter width is $clog2(MAX_BRANCHES+1).
MAX_MEM_OPS, 8, max issued-but-unretired loads/stores; counter width is $clog2(MAX_MEM_OPS+1).
FLUSH_CYCLES, 2, number of cycles held in FLUSH after a mispredict (≥1).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
inst_valid  in  1  IS stage holds a valid decoded instruction (id_packet_out.valid)
inst_is_branch  in  1  cond_branch | uncond_branch of the instruction at issue
inst_is_ld_st  in  1  is_ld_st_inst from the IS stage
inst_is_halt  in  1  halt flag of the instruction at issue
rob_full  in  1  ROB cannot accept an entry this cycle
rs_full  in  1  RS cannot accept an entry this cycle
rob_empty  in  1  ROB holds no entries
br_done  in  1  a branch resolved this cycle
br_mispredict  in  1  qualifies br_done: the resolved branch was mispredicted
mem_retire  in  1  one load/store retired from the LSQ this cycle
issue_fire  out  1  instruction at issue is accepted this cycle
issue_stall  out  1  stall IF/IS this cycle
branch_pending  out  1  ≥1 unresolved branch is older than the instruction at issue
resolve  out  1  last outstanding branch resolved correctly this cycle
kill  out  1  squash speculative state and invalidate the instruction at issue
halted  out  1  sticky: halt has committed and the machine is drained

Behaviour:
- States: RUN, FLUSH, DRAIN, HALTED (registered).
- Reset (asynchronous, active-high) forces state=RUN, br_cnt=0, mem_cnt=0, flush_cnt=0, halted=0.
  - While reset is high: kill=0, resolve=0, branch_pending=0, issue_fire=0, issue_stall=1.
  - Reset mid-FLUSH or mid-DRAIN abandons the operation immediately.
- issue_stall = (state≠RUN) | rob_full | rs_full | (inst_is_branch & br_cnt==MAX_BRANCHES) | (inst_is_ld_st & mem_cnt==MAX_MEM_OPS) | kill.
- issue_fire = inst_valid & ~issue_stall. This is combinational; counters update on the next clock edge.
- Branch counter, next value:
  - mispredict (br_done & br_mispredict): br_cnt ← 0, overriding everything else.
  - otherwise: br_cnt + (issue_fire & inst_is_branch) − (br_done & ~br_mispredict).
  - A simultaneous issue and correct resolve leaves br_cnt unchanged.
  - br_done while br_cnt==0 is ignored; the counter never underflows.
- branch_pending = (br_cnt≠0) & ~kill.
- resolve = br_done & ~br_mispredict & br_cnt==1. This is combinational, so the IS stage clears `speculative` in the same cycle. It is asserted even if a new branch also fires that cycle.
- Memory counter, next value:
  - mispredict: mem_cnt ← 0, because the LSQ flushes squashed ops and never sends mem_retire for them.
  - otherwise: mem_cnt + (issue_fire & inst_is_ld_st) − mem_retire, saturating at 0.
- kill = (br_done & br_mispredict) | (state==FLUSH).
  - The combinational term invalidates the instruction at issue in the mispredict cycle itself.
- Transitions:
  - RUN → FLUSH on mispredict; flush_cnt ← FLUSH_CYCLES−1.
  - RUN → DRAIN when issue_fire & inst_is_halt.
  - FLUSH: flush_cnt decrements each cycle; at flush_cnt==0, go to RUN.
    - A mispredict while in FLUSH reloads flush_cnt = FLUSH_CYCLES−1.
  - DRAIN: no issue.
    - Mispredict → FLUSH: the halt was speculative and is squashed.
    - else rob_empty → HALTED.
    - Mispredict has priority over rob_empty in the same cycle.
  - HALTED: halted=1 and issue_stall=1 until reset; br_done and mem_retire are ignored.
- If both mispredict and halt-issue occur in the same cycle in RUN, the mispredict wins: kill forces issue_stall, so the halt never fires.

Test Plan:
- Reset, then four branches with MAX_BRANCHES=4 and no resolves → br_cnt=4, branch_pending=1; a 5th branch sees issue_stall=1 and issue_fire=0, while a non-branch ALU op still fires.
- br_cnt=1, br_done=1, br_mispredict=0, with a new branch firing in the same cycle → resolve=1 that cycle, br_cnt stays 1, branch_pending stays 1.
- br_cnt=3, mem_cnt=5, then mispredict → kill=1 that cycle plus exactly 2 more cycles (FLUSH_CYCLES=2); br_cnt=0, mem_cnt=0; issue_fire resumes on the 4th cycle.
- Mispredict in the 1st FLUSH cycle → FLUSH extended; kill stays high for 2 cycles after the second mispredict.
- Halt fires with rob_empty=0 → DRAIN with stall=1; rob_empty=1 three cycles later → halted=1 on the next edge and sticky; assert reset → halted=0 immediately (asynchronous).
- Halt fires, then a mispredict arrives in DRAIN in the same cycle as rob_empty=1 → FLUSH (not HALTED), halted stays 0, then return to RUN.

Source files
------------

// File: rtl/issue_ctrl.sv
// Issue-stage sequencing controller. It gates issue on structural and branch/memory limits,
// flushes for a fixed window after a mispredict, and drains the machine after a halt.
module issue_ctrl #(
    parameter int MAX_BRANCHES = 4,
    parameter int MAX_MEM_OPS  = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic inst_valid,
    input  logic inst_is_branch,
    input  logic inst_is_ld_st,
    input  logic inst_is_halt,
    input  logic rob_full,
    input  logic rs_full,
    input  logic rob_empty,
    input  logic br_done,
    input  logic br_mispredict,
    input  logic mem_retire,
    output logic issue_fire,
    output logic issue_stall,
    output logic branch_pending,
    output logic resolve,
    output logic kill,
    output logic halted
);
    localparam int BW = $clog2(MAX_BRANCHES + 1);
    localparam int MW = $clog2(MAX_MEM_OPS + 1);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [BW-1:0] BR_MAX     = BW'(MAX_BRANCHES);
    localparam logic [MW-1:0] MEM_MAX    = MW'(MAX_MEM_OPS);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] br_cnt_q, br_cnt_d;
    logic [MW-1:0] mem_cnt_q, mem_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;

    logic mispredict, correct, retire, br_inc, mem_inc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            br_cnt_q    <= '0;
            mem_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            br_cnt_q    <= br_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        // Once halted, resolution and retire traffic is ignored entirely.
        mispredict = br_done & br_mispredict & (state_q != HALTED);
        correct    = br_done & ~br_mispredict & (state_q != HALTED);
        retire     = mem_retire & (state_q != HALTED);

        kill           = ~reset & (mispredict | (state_q == FLUSH));
        issue_stall    = reset | (state_q != RUN) | rob_full | rs_full
                       | (inst_is_branch & (br_cnt_q == BR_MAX))
                       | (inst_is_ld_st & (mem_cnt_q == MEM_MAX)) | kill;
        issue_fire     = inst_valid & ~issue_stall;
        branch_pending = ~reset & (br_cnt_q != '0) & ~kill;
        resolve        = ~reset & correct & (br_cnt_q == BW'(1));
        halted         = (state_q == HALTED);

        br_inc  = issue_fire & inst_is_branch;
        mem_inc = issue_fire & inst_is_ld_st;

        br_cnt_d = br_cnt_q;
        if (mispredict) begin
            br_cnt_d = '0;
        end else if (br_inc && !(correct && br_cnt_q != '0)) begin
            br_cnt_d = br_cnt_q + BW'(1);
        end else if (!br_inc && correct && br_cnt_q != '0) begin
            br_cnt_d = br_cnt_q - BW'(1);
        end

        // The LSQ drops squashed ops silently, so a mispredict empties the count.
        mem_cnt_d = mem_cnt_q;
        if (mispredict) begin
            mem_cnt_d = '0;
        end else if (mem_inc && !retire) begin
            mem_cnt_d = mem_cnt_q + MW'(1);
        end else if (!mem_inc && retire && mem_cnt_q != '0) begin
            mem_cnt_d = mem_cnt_q - MW'(1);
        end

        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (issue_fire && inst_is_halt) begin
                    state_d = DRAIN;
                end
            end
            FLUSH: begin
                if (mispredict) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FW'(1);
                end
            end
            DRAIN: begin
                if (mispredict) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (rob_empty) begin
                    state_d = HALTED;
                end
            end
            default: state_d = HALTED;
        endcase
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: inputs change 1ns after the rising edge,
// combinational outputs are checked before the next edge.
module tb_issue_ctrl;
    logic clock = 1'b0;
    logic reset;
    logic inst_valid, inst_is_branch, inst_is_ld_st, inst_is_halt;
    logic rob_full, rs_full, rob_empty;
    logic br_done, br_mispredict, mem_retire;
    logic issue_fire, issue_stall, branch_pending, resolve, kill, halted;

    int checks = 0;
    int errors = 0;

    issue_ctrl #(.MAX_BRANCHES(4), .MAX_MEM_OPS(8), .FLUSH_CYCLES(2)) dut (
        .clock(clock), .reset(reset),
        .inst_valid(inst_valid), .inst_is_branch(inst_is_branch),
        .inst_is_ld_st(inst_is_ld_st), .inst_is_halt(inst_is_halt),
        .rob_full(rob_full), .rs_full(rs_full), .rob_empty(rob_empty),
        .br_done(br_done), .br_mispredict(br_mispredict), .mem_retire(mem_retire),
        .issue_fire(issue_fire), .issue_stall(issue_stall),
        .branch_pending(branch_pending), .resolve(resolve),
        .kill(kill), .halted(halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        inst_valid = 0; inst_is_branch = 0; inst_is_ld_st = 0; inst_is_halt = 0;
        rob_full = 0; rs_full = 0; rob_empty = 0;
        br_done = 0; br_mispredict = 0; mem_retire = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset with hostile inputs: outputs must still be quiet.
        idle();
        reset = 1;
        inst_valid = 1; br_done = 1; br_mispredict = 1;
        #12;
        check("rst_kill", kill, 0);
        check("rst_resolve", resolve, 0);
        check("rst_pending", branch_pending, 0);
        check("rst_fire", issue_fire, 0);
        check("rst_stall", issue_stall, 1);
        check("rst_halted", halted, 0);
        tick();
        reset = 0;
        idle();
        tick();

        // Fill the branch window.
        for (int i = 0; i < 4; i++) begin
            idle(); inst_valid = 1; inst_is_branch = 1; settle();
            check("br_fill_fire", issue_fire, 1);
            check("br_fill_pending", branch_pending, i != 0);
            tick();
        end
        idle(); inst_valid = 1; inst_is_branch = 1; settle();
        check("br_full_pending", branch_pending, 1);
        check("br_full_stall", issue_stall, 1);
        check("br_full_fire", issue_fire, 0);
        tick();
        idle(); inst_valid = 1; settle();
        check("alu_when_br_full", issue_fire, 1);
        tick();

        // Resolve three correctly: 4 -> 1, no resolve pulse.
        for (int i = 0; i < 3; i++) begin
            idle(); br_done = 1; settle();
            check("resolve_not_last", resolve, 0);
            tick();
        end
        // Last branch resolves while a new branch fires.
        idle(); inst_valid = 1; inst_is_branch = 1; br_done = 1; settle();
        check("resolve_last", resolve, 1);
        check("resolve_fire", issue_fire, 1);
        tick();
        idle(); settle();
        check("resolve_pending_kept", branch_pending, 1);
        check("resolve_drop", resolve, 0);
        // One more correct resolve: cnt 1 -> 0.
        br_done = 1; settle();
        check("resolve_again", resolve, 1);
        tick();
        idle(); settle();
        check("br_empty_pending", branch_pending, 0);
        // Resolve at zero must not underflow.
        br_done = 1; settle();
        check("resolve_at_zero", resolve, 0);
        tick();
        idle(); settle();
        check("no_underflow_pending", branch_pending, 0);

        // Build br_cnt=3, mem_cnt=5 (fill memory to 8, check limit, retire 3).
        for (int i = 0; i < 3; i++) begin
            idle(); inst_valid = 1; inst_is_branch = 1; tick();
        end
        for (int i = 0; i < 8; i++) begin
            idle(); inst_valid = 1; inst_is_ld_st = 1; settle();
            check("mem_fill_fire", issue_fire, 1);
            tick();
        end
        idle(); inst_valid = 1; inst_is_ld_st = 1; settle();
        check("mem_full_stall", issue_stall, 1);
        check("mem_full_fire", issue_fire, 0);
        for (int i = 0; i < 3; i++) begin
            idle(); mem_retire = 1; tick();
        end

        // Mispredict: kill now plus two FLUSH cycles, counters cleared.
        idle(); inst_valid = 1; br_done = 1; br_mispredict = 1; settle();
        check("misp_kill", kill, 1);
        check("misp_fire", issue_fire, 0);
        check("misp_stall", issue_stall, 1);
        check("misp_no_resolve", resolve, 0);
        tick();
        idle(); inst_valid = 1; settle();
        check("flush1_kill", kill, 1);
        check("flush1_fire", issue_fire, 0);
        check("flush1_pending", branch_pending, 0);
        tick();
        settle();
        check("flush2_kill", kill, 1);
        check("flush2_fire", issue_fire, 0);
        tick();
        settle();
        check("after_flush_kill", kill, 0);
        check("after_flush_fire", issue_fire, 1);
        check("br_cleared", branch_pending, 0);
        // mem_cnt must be 0: eight ld/st fire, ninth stalls.
        for (int i = 0; i < 8; i++) begin
            idle(); inst_valid = 1; inst_is_ld_st = 1; settle();
            check("mem_cleared_fire", issue_fire, 1);
            tick();
        end
        idle(); inst_valid = 1; inst_is_ld_st = 1; settle();
        check("mem_refill_stall", issue_stall, 1);
        // Drain to 0 then two extra retires: must saturate at 0.
        for (int i = 0; i < 10; i++) begin
            idle(); mem_retire = 1; tick();
        end
        for (int i = 0; i < 8; i++) begin
            idle(); inst_valid = 1; inst_is_ld_st = 1; tick();
        end
        idle(); inst_valid = 1; inst_is_ld_st = 1; settle();
        check("mem_sat_stall", issue_stall, 1);
        for (int i = 0; i < 8; i++) begin
            idle(); mem_retire = 1; tick();
        end

        // Mispredict again during the first FLUSH cycle.
        idle(); br_done = 1; br_mispredict = 1; tick();
        idle(); br_done = 1; br_mispredict = 1; settle();
        check("reflush_kill0", kill, 1);
        tick();
        idle(); inst_valid = 1; settle();
        check("reflush_kill1", kill, 1);
        tick();
        settle();
        check("reflush_kill2", kill, 1);
        tick();
        settle();
        check("reflush_done", kill, 0);
        check("reflush_fire", issue_fire, 1);
        tick();

        // Halt, drain for three cycles, then halt commits.
        idle(); inst_valid = 1; inst_is_halt = 1; settle();
        check("halt_fire", issue_fire, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(); inst_valid = 1; settle();
            check("drain_stall", issue_stall, 1);
            check("drain_fire", issue_fire, 0);
            check("drain_halted", halted, 0);
            tick();
        end
        idle(); rob_empty = 1; settle();
        check("drain_empty_halted", halted, 0);
        tick();
        idle(); inst_valid = 1; br_done = 1; br_mispredict = 1; mem_retire = 1; settle();
        check("halted_set", halted, 1);
        check("halted_stall", issue_stall, 1);
        check("halted_no_kill", kill, 0);
        tick();
        settle();
        check("halted_sticky", halted, 1);
        // Asynchronous reset clears halted before any edge.
        #2;
        reset = 1;
        #1;
        check("async_rst_halted", halted, 0);
        idle();
        tick();
        reset = 0;
        tick();

        // Mispredict and halt in the same RUN cycle: mispredict wins.
        idle(); inst_valid = 1; inst_is_halt = 1; br_done = 1; br_mispredict = 1; settle();
        check("misp_vs_halt_fire", issue_fire, 0);
        tick();
        idle(); tick(); tick();
        idle(); inst_valid = 1; settle();
        check("misp_vs_halt_run", issue_fire, 1);
        tick();

        // Mispredict in DRAIN together with rob_empty: FLUSH wins, then RUN.
        idle(); inst_valid = 1; inst_is_halt = 1; settle();
        check("halt2_fire", issue_fire, 1);
        tick();
        idle(); rob_empty = 1; br_done = 1; br_mispredict = 1; settle();
        check("drain_misp_kill", kill, 1);
        tick();
        idle(); rob_empty = 1; inst_valid = 1; settle();
        check("drain_misp_halted", halted, 0);
        check("drain_misp_flush1", kill, 1);
        tick();
        settle();
        check("drain_misp_flush2", kill, 1);
        tick();
        settle();
        check("drain_misp_run", issue_fire, 1);
        check("drain_misp_no_halt", halted, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
